dadd_req_arb: RTL and testbench

//   Round-robin arbiter and sequencer that shares one dadd adder core between NUM_REQ requesters.
//   - Accepts operand pairs over per-requester valid/ready handshakes.
//   - Issues the winner through a registered output stage to the core.
//   - Tags each issue with its requester ID in an in-order ID FIFO.
//   - Routes each core result back as a registered response tagged with that ID.

---
 rtl/dadd_req_arb.sv | 137 +++++++++++++
 tb/tb_dadd_req_arb.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadd_req_arb.sv
// dadd_req_arb: round-robin arbiter that shares one dadd adder core between
// NUM_REQ requesters. Winners are issued through a registered output stage,
// their IDs are queued in issue order, and core results are returned as
// registered responses tagged with the owning requester.
module dadd_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_OUT = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      dadd_in_vld,
  input  logic                      dadd_in_rdy,
  output logic [DATA_W-1:0]         dadd_in_a,
  output logic [DATA_W-1:0]         dadd_in_b,
  input  logic                      dadd_out_vld,
  input  logic [DATA_W:0]           dadd_out_sum,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum,
  output logic                      busy,
  output logic                      err_unf
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  logic             slot_free;
  logic             can_grant;
  logic             grant;
  logic             pop;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  id_mem [MAX_OUT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // The slot can take a new operand when empty or being drained this cycle;
  // the outstanding limit uses the registered count, so a pop in a full
  // cycle only opens the next cycle. Nothing is granted while in reset.
  assign slot_free = !dadd_in_vld || dadd_in_rdy;
  assign can_grant = rst_n && slot_free && (cnt < CNT_W'(MAX_OUT));
  assign grant     = can_grant && win_vld;
  assign pop       = dadd_out_vld && (cnt != '0);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_vld && req_vld[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // One-hot accept to the winner only.
  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[win_id] = 1'b1;
  end

  // Outstanding count after this cycle's push and pop.
  always_comb begin
    cnt_next = cnt;
    if (grant && !pop)      cnt_next = cnt + CNT_W'(1);
    else if (!grant && pop) cnt_next = cnt - CNT_W'(1);
  end

  // Issue stage: load on grant, drop when the core takes it, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dadd_in_vld <= 1'b0;
      dadd_in_a   <= '0;
      dadd_in_b   <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
    end else if (grant) begin
      dadd_in_vld <= 1'b1;
      dadd_in_a   <= req_a[win_id*DATA_W +: DATA_W];
      dadd_in_b   <= req_b[win_id*DATA_W +: DATA_W];
      rr_ptr      <= win_id;
    end else if (dadd_in_rdy) begin
      dadd_in_vld <= 1'b0;
    end
  end

  // ID storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (grant) id_mem[wr_ptr] <= win_id;
  end

  // ID FIFO pointers, outstanding count and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else begin
      if (grant) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

  // Response stage and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_sum <= '0;
      err_unf <= 1'b0;
    end else begin
      rsp_vld <= pop;
      if (pop) begin
        rsp_id  <= id_mem[rd_ptr];
        rsp_sum <= dadd_out_sum;
      end
      if (dadd_out_vld && cnt == '0) err_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dadd_req_arb.sv
// Testbench for dadd_req_arb: the bench plays the requesters and the adder
// core, and keeps a transaction-level model (grant rule, ID queue, core queue).
module tb_dadd_req_arb;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int MAX_OUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            dadd_in_vld;
  logic            dadd_in_rdy;
  logic [DW-1:0]   dadd_in_a;
  logic [DW-1:0]   dadd_in_b;
  logic            dadd_out_vld;
  logic [DW:0]     dadd_out_sum;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [DW:0]     rsp_sum;
  logic            busy;
  logic            err_unf;

  dadd_req_arb #(.NUM_REQ(N), .DATA_W(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .dadd_in_vld(dadd_in_vld),
    .dadd_in_rdy(dadd_in_rdy), .dadd_in_a(dadd_in_a), .dadd_in_b(dadd_in_b),
    .dadd_out_vld(dadd_out_vld), .dadd_out_sum(dadd_out_sum),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // transaction-level model
  bit          m_in_vld;
  logic [7:0]  m_in_a, m_in_b;
  int          m_last;
  int          m_idq[$];
  bit          m_rsp_vld;
  logic [1:0]  m_rsp_id;
  logic [8:0]  m_rsp_sum;
  bit          m_err;

  // core emulation: results in issue order, each with the cycle it may return
  logic [8:0]  core_sum_q[$];
  int          core_due_q[$];
  int          core_lat    = 1;
  int          core_credit = -1;  // -1 unlimited, otherwise results allowed
  bit          spurious    = 1'b0;

  logic [3:0]  obs_rdy, exp_rdy;
  int          exp_gnt;

  task automatic model_reset();
    m_in_vld  = 1'b0;
    m_in_a    = '0;
    m_in_b    = '0;
    m_last    = N - 1;
    m_idq.delete();
    m_rsp_vld = 1'b0;
    m_rsp_id  = '0;
    m_rsp_sum = '0;
    m_err     = 1'b0;
    core_sum_q.delete();
    core_due_q.delete();
  endtask

  // One clock: drive the core output, predict the accept vector, sample it,
  // cross the edge and advance the model. Starts and ends at posedge+1.
  task automatic tick();
    bit full, free;
    int due;
    if (spurious) begin
      dadd_out_vld = 1'b1;
      dadd_out_sum = 9'($urandom);
    end else if (core_credit != 0 && core_sum_q.size() > 0 && core_due_q[0] <= cyc) begin
      dadd_out_vld = 1'b1;
      dadd_out_sum = core_sum_q[0];
    end else begin
      dadd_out_vld = 1'b0;
      dadd_out_sum = 9'($urandom);
    end
    #2;
    free    = !m_in_vld || dadd_in_rdy;
    full    = m_idq.size() >= MAX_OUT;
    exp_gnt = -1;
    if (free && !full)
      for (int k = 1; k <= N; k++)
        if (exp_gnt < 0 && req_vld[(m_last + k) % N]) exp_gnt = (m_last + k) % N;
    exp_rdy = (exp_gnt >= 0) ? 4'(1 << exp_gnt) : 4'b0;
    obs_rdy = req_rdy;
    @(posedge clk);
    if (dadd_out_vld && !spurious) begin
      void'(core_sum_q.pop_front());
      void'(core_due_q.pop_front());
      if (core_credit > 0) core_credit--;
    end
    if (m_in_vld && dadd_in_rdy) begin
      due = cyc + core_lat;
      if (core_due_q.size() > 0 && due <= core_due_q[$]) due = core_due_q[$] + 1;
      core_sum_q.push_back({1'b0, m_in_a} + {1'b0, m_in_b});
      core_due_q.push_back(due);
    end
    if (dadd_out_vld && m_idq.size() > 0) begin
      m_rsp_vld = 1'b1;
      m_rsp_id  = 2'(m_idq.pop_front());
      m_rsp_sum = dadd_out_sum;
    end else begin
      m_rsp_vld = 1'b0;
      if (dadd_out_vld) m_err = 1'b1;
    end
    if (exp_gnt >= 0) begin
      m_in_vld = 1'b1;
      m_in_a   = req_a[exp_gnt*DW +: DW];
      m_in_b   = req_b[exp_gnt*DW +: DW];
      m_last   = exp_gnt;
      m_idq.push_back(exp_gnt);
    end else if (dadd_in_rdy) begin
      m_in_vld = 1'b0;
    end
    spurious = 1'b0;
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    req_vld     = '0;
    dadd_in_rdy = 1'b1;
    core_credit = -1;
    while ((m_in_vld || m_idq.size() > 0 || core_sum_q.size() > 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: outstanding %0d after %0d cycles, want 0", m_idq.size(), n);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n        = 1'b0;
    req_vld      = 4'hF;
    req_a        = $urandom;
    req_b        = $urandom;
    dadd_in_rdy  = 1'b1;
    dadd_out_vld = 1'b0;
    dadd_out_sum = '0;
    #3;
    checks++;
    if (req_rdy !== 4'b0) begin
      errors++; $display("FAIL reset_rdy: got %b want 0000", req_rdy);
    end
    checks++;
    if ({dadd_in_vld, dadd_in_a, dadd_in_b, rsp_vld, rsp_id, rsp_sum, busy, err_unf} !== '0) begin
      errors++;
      $display("FAIL reset_out: got in=%b/%h/%h rsp=%b/%0d/%h busy=%b err=%b want all 0",
               dadd_in_vld, dadd_in_a, dadd_in_b, rsp_vld, rsp_id, rsp_sum, busy, err_unf);
    end
    @(posedge clk);
    #3;
    req_vld = '0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single();
    int seen = 0;
    core_lat    = 3;
    req_a       = $urandom;
    req_b       = $urandom;
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h01;
    req_vld     = 4'b0100;
    dadd_in_rdy = 1'b1;
    tick();
    checks++;
    if (obs_rdy !== 4'b0100 || exp_rdy !== 4'b0100) begin
      errors++; $display("FAIL single_rdy: got %b want 0100", obs_rdy);
    end
    checks++;
    if ({dadd_in_vld, dadd_in_a, dadd_in_b} !== {1'b1, 8'hFF, 8'h01}) begin
      errors++; $display("FAIL single_issue: got %b/%h/%h want 1/ff/01", dadd_in_vld, dadd_in_a, dadd_in_b);
    end
    req_vld = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_rdy !== 4'b0) begin
        errors++; $display("FAIL single_idle_rdy: got %b want 0000", obs_rdy);
      end
      checks++;
      if ({rsp_vld, rsp_id, rsp_sum} !== {m_rsp_vld, m_rsp_id, m_rsp_sum}) begin
        errors++;
        $display("FAIL single_rsp: got %b/%0d/%h want %b/%0d/%h", rsp_vld, rsp_id, rsp_sum, m_rsp_vld, m_rsp_id, m_rsp_sum);
      end
      if (rsp_vld) begin
        seen++;
        checks++;
        if (rsp_id !== 2'd2 || rsp_sum !== 9'h100) begin
          errors++; $display("FAIL single_value: got id=%0d sum=%h want id=2 sum=100", rsp_id, rsp_sum);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL single_count: got %0d responses want 1", seen);
    end
  endtask

  task automatic test_round_robin();
    int prev = 2;  // the single-request scenario last granted requester 2
    int gq[$];
    int g;
    core_lat    = 1;
    req_vld     = 4'hF;
    dadd_in_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req_a = $urandom;
      req_b = $urandom;
      tick();
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++; $display("FAIL rr_rdy: got %b want %b", obs_rdy, exp_rdy);
      end
      if (obs_rdy != 4'b0) begin
        g = 0;
        for (int k = 0; k < N; k++) if (obs_rdy[k]) g = k;
        checks++;
        if (g != (prev + 1) % N) begin
          errors++; $display("FAIL rr_order: got %0d want %0d", g, (prev + 1) % N);
        end
        prev = g;
        gq.push_back(g);
      end
      checks++;
      if ({dadd_in_vld, dadd_in_a, dadd_in_b} !== {m_in_vld, m_in_a, m_in_b}) begin
        errors++; $display("FAIL rr_issue: got %b/%h/%h want %b/%h/%h", dadd_in_vld, dadd_in_a, dadd_in_b, m_in_vld, m_in_a, m_in_b);
      end
      if (rsp_vld) begin
        checks++;
        if (gq.size() == 0 || rsp_id !== 2'(gq[0]) || rsp_sum !== m_rsp_sum) begin
          errors++; $display("FAIL rr_rsp: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, (gq.size() > 0) ? gq[0] : -1, m_rsp_sum);
        end
        if (gq.size() > 0) void'(gq.pop_front());
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] hold_a, hold_b;
    req_vld     = 4'hF;
    req_a       = $urandom;
    req_b       = $urandom;
    dadd_in_rdy = 1'b1;
    tick();
    hold_a      = m_in_a;
    hold_b      = m_in_b;
    dadd_in_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_a = $urandom;
      req_b = $urandom;
      tick();
      checks++;
      if (obs_rdy !== 4'b0) begin
        errors++; $display("FAIL bp_rdy: got %b want 0000", obs_rdy);
      end
      checks++;
      if ({dadd_in_vld, dadd_in_a, dadd_in_b} !== {1'b1, hold_a, hold_b}) begin
        errors++; $display("FAIL bp_hold: got %b/%h/%h want 1/%h/%h", dadd_in_vld, dadd_in_a, dadd_in_b, hold_a, hold_b);
      end
    end
    dadd_in_rdy = 1'b1;
    tick();
    checks++;
    if (obs_rdy === 4'b0 || obs_rdy !== exp_rdy) begin
      errors++; $display("FAIL bp_resume: got %b want %b", obs_rdy, exp_rdy);
    end
    checks++;
    if ({dadd_in_vld, dadd_in_a, dadd_in_b} !== {m_in_vld, m_in_a, m_in_b}) begin
      errors++; $display("FAIL bp_newop: got %b/%h/%h want %b/%h/%h", dadd_in_vld, dadd_in_a, dadd_in_b, m_in_vld, m_in_a, m_in_b);
    end
    drain();
  endtask

  task automatic test_full();
    int n = 0;
    core_credit = 0;
    core_lat    = 1;
    req_vld     = 4'hF;
    dadd_in_rdy = 1'b1;
    while (m_idq.size() < MAX_OUT && n < 10) begin
      req_a = $urandom;
      req_b = $urandom;
      tick();
      n++;
    end
    checks++;
    if (m_idq.size() != MAX_OUT) begin
      errors++; $display("FAIL full_fill: got %0d outstanding want %0d", m_idq.size(), MAX_OUT);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_rdy !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL full_stall: got rdy=%b busy=%b want 0000/1", obs_rdy, busy);
      end
    end
    core_credit = 1;
    tick();
    checks++;
    if (obs_rdy !== 4'b0) begin
      errors++; $display("FAIL full_pop_cycle: got %b want 0000", obs_rdy);
    end
    checks++;
    if ({rsp_vld, rsp_id, rsp_sum} !== {m_rsp_vld, m_rsp_id, m_rsp_sum}) begin
      errors++; $display("FAIL full_rsp: got %b/%0d/%h want %b/%0d/%h", rsp_vld, rsp_id, rsp_sum, m_rsp_vld, m_rsp_id, m_rsp_sum);
    end
    tick();
    checks++;
    if (obs_rdy === 4'b0 || obs_rdy !== exp_rdy) begin
      errors++; $display("FAIL full_next_grant: got %b want %b", obs_rdy, exp_rdy);
    end
    drain();
  endtask

  task automatic test_underflow();
    spurious = 1'b1;
    tick();
    checks++;
    if (rsp_vld !== 1'b0 || err_unf !== 1'b1) begin
      errors++; $display("FAIL unf_flag: got rsp_vld=%b err=%b want 0/1", rsp_vld, err_unf);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (err_unf !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL unf_sticky: got err=%b busy=%b want 1/0", err_unf, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_vld     = 4'($urandom);
      req_a       = $urandom;
      req_b       = $urandom;
      dadd_in_rdy = ($urandom_range(0, 3) != 0);
      core_lat    = $urandom_range(1, 4);
      tick();
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++; $display("FAIL rnd_rdy: cyc %0d got %b want %b", cyc, obs_rdy, exp_rdy);
      end
      checks++;
      if ({dadd_in_vld, dadd_in_a, dadd_in_b} !== {m_in_vld, m_in_a, m_in_b}) begin
        errors++; $display("FAIL rnd_issue: cyc %0d got %b/%h/%h want %b/%h/%h", cyc, dadd_in_vld, dadd_in_a, dadd_in_b, m_in_vld, m_in_a, m_in_b);
      end
      checks++;
      if ({rsp_vld, rsp_id, rsp_sum} !== {m_rsp_vld, m_rsp_id, m_rsp_sum}) begin
        errors++; $display("FAIL rnd_rsp: cyc %0d got %b/%0d/%h want %b/%0d/%h", cyc, rsp_vld, rsp_id, rsp_sum, m_rsp_vld, m_rsp_id, m_rsp_sum);
      end
      checks++;
      if ({busy, err_unf} !== {m_idq.size() != 0, m_err}) begin
        errors++; $display("FAIL rnd_flags: cyc %0d got busy=%b err=%b want %b/%b", cyc, busy, err_unf, m_idq.size() != 0, m_err);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    core_credit = 0;
    req_vld     = 4'hF;
    dadd_in_rdy = 1'b1;
    while (m_idq.size() < 3 && n < 10) begin
      req_a = $urandom;
      req_b = $urandom;
      tick();
      n++;
    end
    req_vld = '0;
    checks++;
    if (busy !== 1'b1 || m_idq.size() != 3) begin
      errors++; $display("FAIL mid_setup: got busy=%b outstanding=%0d want 1/3", busy, m_idq.size());
    end
    req_vld = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 4'b0) begin
      errors++; $display("FAIL mid_rdy: got %b want 0000", req_rdy);
    end
    checks++;
    if ({dadd_in_vld, dadd_in_a, dadd_in_b, rsp_vld, rsp_id, rsp_sum, busy, err_unf} !== '0) begin
      errors++;
      $display("FAIL mid_out: got in=%b/%h/%h rsp=%b/%0d/%h busy=%b err=%b want all 0",
               dadd_in_vld, dadd_in_a, dadd_in_b, rsp_vld, rsp_id, rsp_sum, busy, err_unf);
    end
    model_reset();
    core_credit = -1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_busy: got %b want 0", busy);
    end
    tick();
    checks++;
    if (obs_rdy !== 4'b0001 || exp_rdy !== 4'b0001) begin
      errors++; $display("FAIL mid_first_grant: got %b want 0001", obs_rdy);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    drain();
    test_round_robin();
    test_backpressure();
    test_full();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
